// File: rtl/shift_right_seq.sv
// ============================================================================
// shift_right_seq : iterative right shifter (SRL/SRA), one bit per clock.
// Rev 1.0
// ============================================================================
`default_nettype none

module shift_right_seq #(
  parameter int n = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [n-1:0]           a,
  input  logic [$clog2(n)-1:0]   shamt,
  input  logic                   arith,
  output logic                   busy,
  output logic                   done,
  output logic [n-1:0]           result
);

  localparam int SW = $clog2(n);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]    r_state;
  logic [1:0]    w_next;
  logic [n-1:0]  r_work;
  logic [SW-1:0] r_cnt;
  logic          r_mode;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // A zero shift goes straight to DONE so SHIFT never sees a zero count.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = (shamt != '0) ? SHIFT : DONE;
      SHIFT:   if (r_cnt == SW'(1)) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != IDLE);
    done = (r_state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_work <= '0;
      r_cnt  <= '0;
      r_mode <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_work <= a;
            r_cnt  <= shamt;
            r_mode <= arith;
          end
        end
        SHIFT: begin
          r_work <= {r_mode & r_work[n-1], r_work[n-1:1]};
          r_cnt  <= r_cnt - SW'(1);
        end
        default: ;
      endcase
    end
  end

  assign result = r_work;

endmodule

`default_nettype wire

// File: tb/tb_shift_right_seq.sv
// ============================================================================
// tb_shift_right_seq : table + random vectors with a scoreboard queue.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_shift_right_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [4:0]  shamt;
  logic        arith;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] a;
    logic [4:0]  s;
    logic        ar;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    int          lat;
  } exp_t;

  exp_t sb[$];

  shift_right_seq #(.n(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .shamt  (shamt),
    .arith  (arith),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] va, input logic [4:0] vs, input logic var_);
    logic signed [31:0] sa;
    logic [31:0] r;
    sa = va;
    if (var_) r = sa >>> vs;
    else      r = va >> vs;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Assumes the DUT is idle; inputs are scrambled right after capture.
  task automatic run_op(input logic [31:0] va, input logic [4:0] vs, input logic var_,
                        input logic [31:0] vexp);
    exp_t e;
    bit   got;
    e.res = vexp;
    e.lat = int'(vs) + 1;
    sb.push_back(e);
    a = va; shamt = vs; arith = var_; start = 1'b1;
    tick();
    start = 1'b0;
    a = $urandom; shamt = 5'($urandom); arith = 1'($urandom);
    got = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      check("busy_in_op", {31'd0, busy}, 32'd1);
      if (done) begin
        e = sb.pop_front();
        check("latency", 32'(k), 32'(e.lat));
        check("result", result, e.res);
        got = 1'b1;
        break;
      end
      tick();
    end
    if (!got) begin
      n_vec++; n_err++;
      $display("FAIL done_timeout: got no done expected done within 40 cycles");
      void'(sb.pop_front());
    end
    tick();
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_done", {31'd0, done}, 32'd0);
    check("idle_hold", result, vexp);
  endtask

  vec_t tbl[5];

  initial begin
    int dcount;
    tbl[0] = '{32'h8000_0000, 5'd4,  1'b0, 32'h0800_0000};
    tbl[1] = '{32'h8000_0000, 5'd4,  1'b1, 32'hF800_0000};
    tbl[2] = '{32'h1234_5678, 5'd0,  1'b1, 32'h1234_5678};
    tbl[3] = '{32'h8000_0001, 5'd31, 1'b1, 32'hFFFF_FFFF};
    tbl[4] = '{32'h8000_0001, 5'd31, 1'b0, 32'h0000_0001};

    // Reset with start held high: nothing may be captured.
    rst = 1'b1; start = 1'b1; a = 32'hDEAD_BEEF; shamt = 5'd3; arith = 1'b1;
    tick(); tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);

    // First edge with rst low captures (zero shift -> done next cycle).
    rst = 1'b0; a = 32'hA5A5_A5A5; shamt = 5'd0; arith = 1'b0;
    tick();
    start = 1'b0;
    check("first_cap_done", {31'd0, done}, 32'd1);
    check("first_cap_result", result, 32'hA5A5_A5A5);
    tick();

    for (int i = 0; i < 5; i++)
      run_op(tbl[i].a, tbl[i].s, tbl[i].ar, tbl[i].exp);

    for (int i = 0; i < 20; i++) begin
      logic [31:0] ra;
      logic [4:0]  rs;
      logic        rr;
      ra = $urandom; rs = 5'($urandom); rr = 1'($urandom);
      run_op(ra, rs, rr, model(ra, rs, rr));
    end

    // Start held high with inputs churning: one done, captured values only.
    a = 32'h8000_0000; shamt = 5'd4; arith = 1'b1; start = 1'b1;
    tick();
    dcount = 0;
    for (int k = 1; k <= 5; k++) begin
      a = $urandom; shamt = 5'($urandom); arith = 1'($urandom);
      if (done) dcount++;
      if (k == 5) begin
        check("held_done_t5", {31'd0, done}, 32'd1);
        check("held_result", result, 32'hF800_0000);
        start = 1'b0;
      end
      tick();
    end
    for (int k = 0; k < 6; k++) begin
      if (done) dcount++;
      tick();
    end
    check("held_done_count", 32'(dcount), 32'd1);

    // Reset in the middle of SHIFT aborts with no done pulse.
    a = 32'hFFFF_0000; shamt = 5'd10; arith = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_result", result, 32'd0);
    dcount = 0;
    for (int k = 0; k < 15; k++) begin
      if (done || busy) dcount++;
      tick();
    end
    check("abort_no_activity", 32'(dcount), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/shift_right_seq.md
SHIFT_RIGHT_SEQ -- requirements
Module: shift_right_seq

Interface
REQ-001 The block SHALL have parameter n, default 32, giving the data width; legal values are powers of two, at least 4.
REQ-002 The block SHALL have derived localparam SW = clog2(n), giving the shift-amount width (5 when n=32).
REQ-003 Port clk, input, 1 bit: single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port start, input, 1 bit: operation request, sampled only in IDLE.
REQ-006 Port a, input, n bits: operand to shift.
REQ-007 Port shamt, input, SW bits: shift amount, range 0..n-1.
REQ-008 Port arith, input, 1 bit: 1 = arithmetic right shift (SRA), 0 = logical right shift (SRL).
REQ-009 Port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-010 Port done, output, 1 bit: one-cycle pulse; result is valid in that cycle.
REQ-011 Port result, output, n bits: shifted value, driven directly from the working register.

Function
REQ-012 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-013 In IDLE with start=1, the block SHALL capture a into the working register, shamt into a down-counter, and arith into a mode flag, all on the same edge.
REQ-014 On that capture edge, the next state SHALL be SHIFT if shamt != 0, and DONE if shamt == 0.
REQ-015 In SHIFT, each edge SHALL shift the working register right by exactly one bit and decrement the counter by 1.
REQ-016 The bit filling the MSB on each SHIFT edge SHALL be the current MSB when the mode flag is 1, and 0 when it is 0.
REQ-017 In SHIFT, the edge on which the counter equals 1 SHALL perform the final shift and move the state to DONE.
REQ-018 In DONE, done SHALL be 1 for exactly one cycle, and the next state SHALL be IDLE unconditionally.
REQ-019 Latency: if start is accepted in cycle T, done SHALL be high in cycle T+1+shamt; for shamt=0, that is cycle T+1.
REQ-020 Throughput: back-to-back operations SHALL be spaced at least shamt+2 cycles apart, because start is accepted only in IDLE.
REQ-021 Start asserted in SHIFT or DONE SHALL be ignored, with no effect on the working register, counter, mode flag or state.
REQ-022 Changes on a, shamt or arith after the capture edge SHALL NOT affect the operation in progress.
REQ-023 During SHIFT, result SHALL show intermediate values, which are defined but not valid.
REQ-024 result SHALL be valid when done=1 and SHALL hold that value through IDLE until the next capture edge.
REQ-025 The final result SHALL equal a >> shamt (logical) or a >>> shamt (arithmetic), bit-exact for all n-bit operands.
REQ-026 The counter SHALL never decrement below 0 or wrap, and SHIFT SHALL never be entered with a counter value of 0.
REQ-027 busy SHALL be 1 in SHIFT and DONE and 0 in IDLE; it is combinational from state.
REQ-028 done SHALL be combinational from state and SHALL NOT depend on start.

Reset
REQ-029 When rst=1 on a rising edge, the block SHALL set state=IDLE, working register (result)=0, counter=0 and mode flag=0.
REQ-030 After that reset edge, busy SHALL be 0 and done SHALL be 0.
REQ-031 rst SHALL take priority over start and over any in-flight operation, including mid-SHIFT and in DONE.
REQ-032 No done pulse SHALL be produced for an operation aborted by reset.
REQ-033 Start held high together with rst SHALL be ignored; the first possible capture is on the first edge with rst=0.

Verification
REQ-034 With n=32, a=0x80000000, shamt=4, arith=0 and start pulsed in cycle T: done SHALL be high in cycle T+5 with result=0x08000000, and busy SHALL be high in cycles T+1..T+5.
REQ-035 With the same stimulus as REQ-034 but arith=1: result SHALL be 0xF8000000 in cycle T+5.
REQ-036 With a=0x12345678, shamt=0, arith=1: done SHALL be high in cycle T+1 with result=0x12345678, and SHIFT SHALL never be entered.
REQ-037 With a=0x80000001, shamt=31: arith=1 SHALL give result=0xFFFFFFFF in cycle T+32, and arith=0 SHALL give result=0x00000001.
REQ-038 With start held high and a, shamt and arith changing every cycle during an operation: only the values captured in cycle T SHALL be used, and exactly one done pulse SHALL occur.
REQ-039 With rst asserted during SHIFT (e.g. shamt=10, rst in cycle T+3): in cycle T+4, busy SHALL be 0, done SHALL be 0 and result SHALL be 0, and no done pulse SHALL follow.
